// File: rtl/pe_input_feeder.sv
// pe_input_feeder: streams a channel-inner/pixel-outer tile from the global buffer to a PE Input rdy/ack port
module pe_input_feeder #(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int PCHW = 4,
  parameter int TWW  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [AW-1:0]   i_base_addr,
  input  logic [AW-1:0]   i_ch_stride,
  input  logic [PCHW-1:0] i_pch,
  input  logic [TWW-1:0]  i_row_tile,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_mem_re,
  output logic [AW-1:0]   o_mem_addr,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_Input_rdy,
  input  logic            i_Input_ack,
  output logic [DW-1:0]   o_Input_data
);
  localparam int CW = PCHW + TWW;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [PCHW-1:0] pch_q, c_q;
  logic [AW-1:0]   stride_q, row_q, off_q;
  logic [CW-1:0]   total_q, issued_q, xfer_q;
  logic [DW-1:0]   f0, f1;
  logic [1:0]      occ, wi;
  logic            inflight, done_q, zero, pop, pop_f, wr, last, re;
  // Handshake, FIFO bookkeeping and read-issue decisions; a word landing from the buffer is visible to the PE in the same cycle
  always_comb begin
    zero         = i_pch == '0 || i_row_tile == '0;
    o_Input_rdy  = state == RUN && (occ != 2'd0 || inflight);
    o_Input_data = occ != 2'd0 ? f0 : inflight ? i_mem_rdata : '0;
    pop          = o_Input_rdy && i_Input_ack;
    pop_f        = pop && occ != 2'd0;
    wr           = inflight && !(pop && occ == 2'd0);
    wi           = occ - 2'(pop_f);
    last         = pop && xfer_q == total_q - CW'(1);
    re           = state == RUN && issued_q != total_q && (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
    o_mem_re     = re;
    o_mem_addr   = row_q + off_q;
    o_busy       = state == RUN;
    o_done       = done_q;
  end
  // Next state: flush aborts, a zero-sized job never leaves IDLE, RUN ends on the final transfer
  always_comb begin
    state_n = i_flush ? IDLE : state == IDLE ? (i_start && !zero ? RUN : IDLE) : last ? IDLE : RUN;
  end
  // State, FIFO storage and incremental address walk (row start + channel offset)
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state    <= IDLE;
      occ      <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      c_q      <= '0;
      row_q    <= '0;
      off_q    <= '0;
      issued_q <= '0;
      xfer_q   <= '0;
    end else begin
      state    <= state_n;
      done_q   <= (state == IDLE && i_start && zero) || last;
      inflight <= re;
      occ      <= occ + 2'(wr) - 2'(pop_f);
      f0       <= wr && wi == 2'd0 ? i_mem_rdata : pop_f ? f1 : f0;
      f1       <= wr && wi == 2'd1 ? i_mem_rdata : f1;
      if (state == IDLE) begin
        if (i_start) begin
          pch_q    <= i_pch;
          stride_q <= i_ch_stride;
          total_q  <= CW'(i_pch) * CW'(i_row_tile);
          row_q    <= i_base_addr;
          off_q    <= '0;
          c_q      <= '0;
          issued_q <= '0;
          xfer_q   <= '0;
        end
      end else begin
        if (re) begin
          issued_q <= issued_q + CW'(1);
          if (c_q == pch_q - PCHW'(1)) begin
            c_q   <= '0;
            row_q <= row_q + AW'(1);
            off_q <= '0;
          end else begin
            c_q   <= c_q + PCHW'(1);
            off_q <= off_q + stride_q;
          end
        end
        if (pop) xfer_q <= xfer_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pe_input_feeder.sv
// tb_pe_input_feeder: randomized self-checking bench against a loop-nest reference model
module tb_pe_input_feeder;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_flush = 0, i_Input_ack = 0;
  logic [9:0] i_base_addr = 0, i_ch_stride = 0, o_mem_addr;
  logic [3:0] i_pch = 0;
  logic [7:0] i_row_tile = 0;
  logic [15:0] i_mem_rdata = 0, o_Input_data;
  logic o_busy, o_done, o_mem_re, o_Input_rdy;
  logic [15:0] mem [1024];
  int checks = 0, passes = 0;

  pe_input_feeder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_flush(i_flush),
    .i_base_addr(i_base_addr), .i_ch_stride(i_ch_stride), .i_pch(i_pch), .i_row_tile(i_row_tile),
    .o_busy(o_busy), .o_done(o_done), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .o_Input_rdy(o_Input_rdy), .i_Input_ack(i_Input_ack),
    .o_Input_data(o_Input_data)
  );

  always #5 i_clk = ~i_clk;

  // buffer model: one-cycle read latency
  always @(posedge i_clk) if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // mode 0: ack=1, 1: ack 1,0,0 pattern, 2: random ack, 3: ack=1 with a start pulse during RUN
  task automatic run_job(input logic [9:0] base, input logic [9:0] stride, input logic [3:0] pch,
                         input logic [7:0] tile, input int mode, input string name);
    logic [9:0] aq[$];
    logic [15:0] dq[$];
    int n, nre, got, cyc, done_cyc, first_re, first_rdy, limit;
    logic prev_rdy, prev_ack;
    logic [15:0] prev_data;
    n = int'(pch) * int'(tile);
    for (int p = 0; p < int'(tile); p++)
      for (int c = 0; c < int'(pch); c++) begin
        aq.push_back(10'(int'(base) + c * int'(stride) + p));
        dq.push_back(mem[10'(int'(base) + c * int'(stride) + p)]);
      end
    nre = 0; got = 0; done_cyc = -1; first_re = -1; first_rdy = -1; limit = 4 * n + 10;
    prev_rdy = 0; prev_ack = 0; prev_data = 0;
    i_start = 1; i_base_addr = base; i_ch_stride = stride; i_pch = pch; i_row_tile = tile;
    step();
    i_start = 0;
    for (cyc = 1; cyc <= limit; cyc++) begin
      i_Input_ack = mode == 1 ? (cyc % 3) == 2 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start = mode == 3 && cyc == 3;
      i_pch = 1; i_row_tile = 1; i_base_addr = 10'h155;
      #1;
      if (o_mem_re) begin
        if (first_re < 0) first_re = cyc;
        checks++;
        if (nre >= n || o_mem_addr !== aq[nre]) $display("FAIL %s addr#%0d got %h want %h", name, nre, o_mem_addr, nre < n ? aq[nre] : 10'h0);
        else passes++;
        nre++;
      end
      if (prev_rdy && !prev_ack) begin
        checks++;
        if (o_Input_rdy !== 1'b1 || o_Input_data !== prev_data) $display("FAIL %s hold rdy=%b data=%h want rdy=1 data=%h", name, o_Input_rdy, o_Input_data, prev_data);
        else passes++;
      end
      if (o_Input_rdy && first_rdy < 0) first_rdy = cyc;
      if (o_Input_rdy && i_Input_ack) begin
        checks++;
        if (got >= n || o_Input_data !== dq[got]) $display("FAIL %s word#%0d got %h want %h", name, got, o_Input_data, got < n ? dq[got] : 16'h0);
        else passes++;
        got++;
      end
      if (nre - got > 2) begin
        checks++;
        $display("FAIL %s buffered got %0d want <=2", name, nre - got);
      end
      prev_rdy = o_Input_rdy; prev_ack = i_Input_ack; prev_data = o_Input_data;
      if (o_done) begin
        done_cyc = cyc;
        checks++;
        if (o_busy !== 1'b0) $display("FAIL %s busy_at_done got %b want 0", name, o_busy);
        else passes++;
        break;
      end
      step();
    end
    i_start = 0;
    checks++;
    if (done_cyc < 0) $display("FAIL %s done_timeout got none want done", name); else passes++;
    checks++;
    if (got !== n || nre !== n) $display("FAIL %s counts got xfer=%0d reads=%0d want %0d", name, got, nre, n); else passes++;
    checks++;
    if (first_re !== 1 || first_rdy !== 2) $display("FAIL %s first got re@%0d rdy@%0d want 1,2", name, first_re, first_rdy); else passes++;
    if (mode == 0 || mode == 3) begin
      checks++;
      if (done_cyc !== n + 2) $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, n + 2); else passes++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1; i_start = 1; i_pch = 2; i_row_tile = 2;
    repeat (3) step();
    checks++;
    if ({o_busy, o_done, o_mem_re, o_Input_rdy} !== 4'b0 || o_mem_addr !== 10'h0 || o_Input_data !== 16'h0)
      $display("FAIL reset outputs got busy=%b done=%b re=%b rdy=%b addr=%h data=%h want all 0", o_busy, o_done, o_mem_re, o_Input_rdy, o_mem_addr, o_Input_data);
    else passes++;
    i_rst = 0; i_start = 0;
    step();
    checks++;
    if (o_busy !== 1'b0) $display("FAIL reset_start_dropped busy got %b want 0", o_busy); else passes++;
  endtask

  task automatic test_basic();
    run_job(10'h010, 10'h040, 2, 3, 0, "basic");
    step();
  endtask

  task automatic test_backpressure();
    run_job(10'h010, 10'h040, 2, 3, 1, "backpressure");
    step();
    for (int k = 0; k < 4; k++) begin
      run_job(10'($urandom), 10'($urandom), 4'($urandom_range(1, 12)), 8'($urandom_range(1, 20)), 2, "random");
      step();
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 2; k++) begin
      i_start = 1; i_pch = k == 0 ? 4'd0 : 4'd3; i_row_tile = k == 0 ? 8'd5 : 8'd0;
      step();
      i_start = 0;
      checks++;
      if (o_done !== 1'b1 || o_mem_re !== 1'b0 || o_Input_rdy !== 1'b0 || o_busy !== 1'b0)
        $display("FAIL zero%0d c1 got done=%b re=%b rdy=%b busy=%b want 1,0,0,0", k, o_done, o_mem_re, o_Input_rdy, o_busy);
      else passes++;
      step();
      checks++;
      if (o_done !== 1'b0 || o_mem_re !== 1'b0 || o_Input_rdy !== 1'b0)
        $display("FAIL zero%0d c2 got done=%b re=%b rdy=%b want 0,0,0", k, o_done, o_mem_re, o_Input_rdy);
      else passes++;
    end
  endtask

  task automatic test_flush();
    int n = 0;
    i_start = 1; i_base_addr = 10'h100; i_ch_stride = 10'h010; i_pch = 4; i_row_tile = 4; i_Input_ack = 1;
    step();
    i_start = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      #1;
      if (o_Input_rdy && i_Input_ack) n++;
      step();
    end
    checks++;
    if (n !== 3) $display("FAIL flush_setup transfers got %0d want 3", n); else passes++;
    i_flush = 1; i_Input_ack = 0;
    step();
    i_flush = 0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_Input_rdy !== 1'b0 || o_done !== 1'b0 || o_mem_re !== 1'b0)
      $display("FAIL flush_next got busy=%b rdy=%b done=%b re=%b want 0,0,0,0", o_busy, o_Input_rdy, o_done, o_mem_re);
    else passes++;
    step();
    checks++;
    if (o_Input_rdy !== 1'b0 || o_done !== 1'b0) $display("FAIL flush_late got rdy=%b done=%b want 0,0", o_Input_rdy, o_done); else passes++;
    run_job(10'h200, 10'h003, 1, 2, 0, "after_flush");
    step();
  endtask

  task automatic test_back_to_back();
    run_job(10'h020, 10'h005, 3, 2, 0, "b2b_first");
    run_job(10'h300, 10'h011, 2, 2, 0, "b2b_second");
    step();
    run_job(10'h040, 10'h002, 2, 3, 3, "start_busy");
    step();
    run_job(10'h3FE, 10'h001, 1, 4, 0, "wrap");
    step();
  endtask

  task automatic test_reset_mid();
    i_start = 1; i_base_addr = 10'h010; i_ch_stride = 10'h040; i_pch = 2; i_row_tile = 3; i_Input_ack = 1;
    step();
    i_start = 0;
    #1;
    checks++;
    if (o_mem_re !== 1'b1) $display("FAIL rst_mid_re got %b want 1", o_mem_re); else passes++;
    i_rst = 1;
    step();
    i_rst = 0;
    checks++;
    if ({o_busy, o_done, o_mem_re, o_Input_rdy} !== 4'b0 || o_mem_addr !== 10'h0 || o_Input_data !== 16'h0)
      $display("FAIL rst_mid outputs got busy=%b done=%b re=%b rdy=%b addr=%h data=%h want all 0", o_busy, o_done, o_mem_re, o_Input_rdy, o_mem_addr, o_Input_data);
    else passes++;
    step();
    checks++;
    if (o_Input_rdy !== 1'b0 || o_Input_data !== 16'h0 || o_done !== 1'b0)
      $display("FAIL rst_mid_discard got rdy=%b data=%h done=%b want 0,0,0", o_Input_rdy, o_Input_data, o_done);
    else passes++;
    run_job(10'h010, 10'h040, 2, 3, 0, "after_reset");
    step();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 16'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
